alu_share_arbiter: RTL and testbench

Shares one combinational ALU instance among NUM_REQ requesters, for example the execute stage, the branch-compare unit and the address-generation unit.
- Each requester presents operands and a 4-bit ALU control code over a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and drives the shared ALU.
- The result, zero flag and requester ID are captured in a single-entry output buffer with valid/ready backpressure.

---
 rtl/alu_share_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters using round-robin arbitration.
// A single-entry response buffer with valid/ready backpressure captures each result.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b_i,
  input  logic [NUM_REQ*4-1:0]          req_alu_control_i,
  output logic [DATA_WIDTH-1:0]         alu_operand_a_o,
  output logic [DATA_WIDTH-1:0]         alu_operand_b_o,
  output logic [3:0]                    alu_control_o,
  input  logic [DATA_WIDTH-1:0]         alu_result_i,
  input  logic                          alu_zero_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_result_o,
  output logic                          rsp_zero_o,
  output logic [ID_WIDTH-1:0]           rsp_id_o
);

  localparam logic [3:0]        CtrlAdd = 4'b0010;
  localparam logic [ID_WIDTH:0] NumReqW = (ID_WIDTH + 1)'(NUM_REQ);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                state_q, state_d;
  logic                  can_accept;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH:0]     cand;
  logic [ID_WIDTH:0]     ptr_inc;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  // Buffer FSM: state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant_valid) state_d = StFull;
      StFull: begin
        if (grant_valid) begin
          state_d = StFull;
        end else if (rsp_ready_i) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Buffer FSM: outputs. Reset masks acceptance so nothing is granted in the reset cycle.
  always_comb begin
    rsp_valid_o = (state_q == StFull);
    can_accept  = rst_ni && ((state_q == StEmpty) || rsp_ready_i);
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(k);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (can_accept && !grant_valid && req_valid_i[cand[ID_WIDTH-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  // Idle drive is a stable ADD of zeros.
  always_comb begin
    req_ready_o     = '0;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    alu_control_o   = CtrlAdd;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && (grant_idx == ID_WIDTH'(i))) begin
        req_ready_o[i]  = 1'b1;
        alu_operand_a_o = req_operand_a_i[i*DATA_WIDTH +: DATA_WIDTH];
        alu_operand_b_o = req_operand_b_i[i*DATA_WIDTH +: DATA_WIDTH];
        alu_control_o   = req_alu_control_i[i*4 +: 4];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (ID_WIDTH + 1)'(1);
    if (ptr_inc == NumReqW) ptr_inc = '0;
    rr_ptr_d = rr_ptr_q;
    result_d = result_q;
    zero_d   = zero_q;
    id_d     = id_q;
    if (grant_valid) begin
      rr_ptr_d = ptr_inc[ID_WIDTH-1:0];
      result_d = alu_result_i;
      zero_d   = alu_zero_i;
      id_d     = grant_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      id_q     <= id_d;
    end
  end

  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_id_o     = id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (3 requesters): behavioural model compared every
// cycle, plus hand-computed literal expectations for the key transactions.
module tb_alu_share_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   req_a [N];
  logic [W-1:0]   req_b [N];
  logic [3:0]     req_c [N];
  logic [N*W-1:0] flat_a, flat_b;
  logic [N*4-1:0] flat_c;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [3:0]     alu_ctrl;
  logic           alu_zero;
  logic           rsp_valid, rsp_ready, rsp_zero;
  logic [W-1:0]   rsp_result;
  logic [1:0]     rsp_id;

  assign flat_a = {req_a[2], req_a[1], req_a[0]};
  assign flat_b = {req_b[2], req_b[1], req_b[0]};
  assign flat_c = {req_c[2], req_c[1], req_c[0]};

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0110: return a - b;
      4'b0111: return {31'd0, $signed(a) < $signed(b)};
      4'b1000: return a << b[4:0];
      4'b1001: return a >> b[4:0];
      4'b1010: return $unsigned($signed(a) >>> b[4:0]);
      4'b1100: return a ^ b;
      4'b1101: return {31'd0, a < b};
      default: return a + b;
    endcase
  endfunction

  // Shared ALU seen by the DUT.
  assign alu_result = alu_ref(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  alu_share_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_operand_a_i  (flat_a),
    .req_operand_b_i  (flat_b),
    .req_alu_control_i(flat_c),
    .alu_operand_a_o  (alu_a),
    .alu_operand_b_o  (alu_b),
    .alu_control_o    (alu_ctrl),
    .alu_result_i     (alu_result),
    .alu_zero_i       (alu_zero),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_result_o     (rsp_result),
    .rsp_zero_o       (rsp_zero),
    .rsp_id_o         (rsp_id)
  );

  // Model: buffer contents and rotation pointer as plain variables.
  logic         m_valid  = 1'b0;
  logic [W-1:0] m_result = '0;
  logic         m_zero   = 1'b0;
  int           m_id     = 0;
  int           m_ptr    = 0;
  int           m_grant;
  logic [N-1:0] exp_ready;
  logic [W-1:0] exp_a, exp_b;
  logic [3:0]   exp_c;

  always_comb begin
    m_grant   = -1;
    exp_ready = '0;
    exp_a     = '0;
    exp_b     = '0;
    exp_c     = 4'b0010;
    if (rst_n && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (m_grant < 0 && req_valid[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
      end
    end
    if (m_grant >= 0) begin
      exp_ready[m_grant] = 1'b1;
      exp_a = req_a[m_grant];
      exp_b = req_b[m_grant];
      exp_c = req_c[m_grant];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_result <= '0;
      m_zero   <= 1'b0;
      m_id     <= 0;
      m_ptr    <= 0;
    end else if (m_grant >= 0) begin
      m_valid  <= 1'b1;
      m_result <= alu_ref(exp_a, exp_b, exp_c);
      m_zero   <= (alu_ref(exp_a, exp_b, exp_c) == '0);
      m_id     <= m_grant;
      m_ptr    <= (m_grant + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Literal expectations set by the stimulus, checked at the next falling edge.
  logic         started = 1'b0;
  logic         lit_ready_en = 1'b0, lit_rsp_en = 1'b0, lit_data_en = 1'b0, lit_ctrl_en = 1'b0;
  logic [N-1:0] lit_ready;
  logic         lit_v, lit_z;
  logic [W-1:0] lit_res;
  logic [1:0]   lit_id;
  logic [3:0]   lit_ctrl;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", W'(req_ready), W'(exp_ready));
      chk("alu_operand_a", alu_a, exp_a);
      chk("alu_operand_b", alu_b, exp_b);
      chk("alu_control", W'(alu_ctrl), W'(exp_c));
      chk("rsp_valid", W'(rsp_valid), W'(m_valid));
      if (m_valid) begin
        chk("rsp_result", rsp_result, m_result);
        chk("rsp_zero", W'(rsp_zero), W'(m_zero));
        chk("rsp_id", W'(rsp_id), W'(m_id));
      end
      if (lit_ready_en) chk("lit_req_ready", W'(req_ready), W'(lit_ready));
      if (lit_ctrl_en) chk("lit_alu_control", W'(alu_ctrl), W'(lit_ctrl));
      if (lit_rsp_en) chk("lit_rsp_valid", W'(rsp_valid), W'(lit_v));
      if (lit_rsp_en && lit_data_en) begin
        chk("lit_rsp_result", rsp_result, lit_res);
        chk("lit_rsp_zero", W'(rsp_zero), W'(lit_z));
        chk("lit_rsp_id", W'(rsp_id), W'(lit_id));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    lit_ready_en = 1'b0;
    lit_rsp_en   = 1'b0;
    lit_data_en  = 1'b0;
    lit_ctrl_en  = 1'b0;
  endtask

  task automatic exp_rdy(input logic [N-1:0] r);
    lit_ready_en = 1'b1;
    lit_ready    = r;
  endtask

  task automatic exp_rsp(input logic v, input logic [W-1:0] res, input logic z,
                         input logic [1:0] id, input logic data);
    lit_rsp_en  = 1'b1;
    lit_data_en = data;
    lit_v       = v;
    lit_res     = res;
    lit_z       = z;
    lit_id      = id;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] c);
    req_valid[i] = v;
    req_a[i]     = a;
    req_b[i]     = b;
    req_c[i]     = c;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, 4'b0000);
    tick();
    started = 1'b1;
    // Still in reset with a pending request: no grant, buffer cleared.
    set_req(0, 1'b1, 32'd5, 32'd3, 4'b0010);
    exp_rdy(3'b000);
    exp_rsp(1'b0, 32'd0, 1'b0, 2'd0, 1'b1);
    tick();
    rst_n = 1'b1;
    exp_rdy(3'b001);
    tick();
    // Both busy requesters; rr_ptr=1 after the first grant.
    set_req(0, 1'b1, 32'd7, 32'd7, 4'b0110);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0111);
    exp_rsp(1'b1, 32'd8, 1'b0, 2'd0, 1'b1);
    exp_rdy(3'b010);
    tick();
    exp_rsp(1'b1, 32'd1, 1'b0, 2'd1, 1'b1);
    exp_rdy(3'b001);
    tick();
    exp_rsp(1'b1, 32'd0, 1'b1, 2'd0, 1'b1);
    exp_rdy(3'b010);
    tick();
    // Backpressure for three cycles.
    rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      exp_rsp(1'b1, 32'd1, 1'b0, 2'd1, 1'b1);
      exp_rdy(3'b000);
      if (s < 2) tick();
    end
    tick();
    rsp_ready = 1'b1;
    exp_rdy(3'b001);
    exp_rsp(1'b1, 32'd1, 1'b0, 2'd1, 1'b1);
    tick();
    set_req(0, 1'b0, '0, '0, 4'b0000);
    exp_rsp(1'b1, 32'd0, 1'b1, 2'd0, 1'b1);
    exp_rdy(3'b010);
    tick();
    set_req(1, 1'b0, '0, '0, 4'b0000);
    exp_rsp(1'b1, 32'd1, 1'b0, 2'd1, 1'b1);
    exp_rdy(3'b000);
    tick();
    // rr_ptr=2: requester 2 first, then wrap past idle requester 0 to 1.
    set_req(1, 1'b1, 32'd9, 32'd4, 4'b0110);
    set_req(2, 1'b1, 32'd3, 32'd3, 4'b1100);
    exp_rsp(1'b0, '0, 1'b0, 2'd0, 1'b0);
    exp_rdy(3'b100);
    tick();
    set_req(2, 1'b0, '0, '0, 4'b0000);
    exp_rsp(1'b1, 32'd0, 1'b1, 2'd2, 1'b1);
    exp_rdy(3'b010);
    tick();
    set_req(1, 1'b0, '0, '0, 4'b0000);
    exp_rsp(1'b1, 32'd5, 1'b0, 2'd1, 1'b1);
    exp_rdy(3'b000);
    tick();
    // Fill and stall, then reset while full.
    set_req(0, 1'b1, 32'd1, 32'd2, 4'b0001);
    rsp_ready = 1'b0;
    exp_rdy(3'b001);
    tick();
    set_req(0, 1'b1, 32'd2, 32'd2, 4'b0010);
    set_req(1, 1'b1, 32'd1, 32'd1, 4'b0000);
    exp_rsp(1'b1, 32'd3, 1'b0, 2'd0, 1'b1);
    exp_rdy(3'b000);
    tick();
    rst_n = 1'b0;
    exp_rdy(3'b000);
    exp_rsp(1'b1, 32'd3, 1'b0, 2'd0, 1'b1);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    exp_rsp(1'b0, 32'd0, 1'b0, 2'd0, 1'b1);
    exp_rdy(3'b001);
    tick();
    set_req(0, 1'b0, '0, '0, 4'b0000);
    exp_rsp(1'b1, 32'd4, 1'b0, 2'd0, 1'b1);
    exp_rdy(3'b010);
    tick();
    set_req(1, 1'b0, '0, '0, 4'b0000);
    exp_rsp(1'b1, 32'd1, 1'b0, 2'd1, 1'b1);
    exp_rdy(3'b000);
    tick();
    // Undefined control code passes through and behaves as ADD.
    set_req(0, 1'b1, 32'h10, 32'h20, 4'b0011);
    exp_ctrl_set();
    exp_rdy(3'b001);
    tick();
    set_req(0, 1'b0, '0, '0, 4'b0000);
    exp_rsp(1'b1, 32'h30, 1'b0, 2'd0, 1'b1);
    tick();
    tick();
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic exp_ctrl_set();
    lit_ctrl_en = 1'b1;
    lit_ctrl    = 4'b0011;
  endtask

endmodule
